// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, idle select, FSM states, decode helpers.
// Optional build macro MUL_HI_WB_EN is consumed by alu_op_sequencer.sv.
`timescale 1ns/1ps
package alu_op_sequencer_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0011;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b0111;
    localparam logic [OP_W-1:0] OP_NAND = 4'b1000;
    localparam logic [OP_W-1:0] OP_NOR  = 4'b1001;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b1011;
    localparam logic [OP_W-1:0] OP_NOP0 = 4'b1100;
    localparam logic [OP_W-1:0] OP_NOP1 = 4'b1110;
    localparam logic [OP_W-1:0] OP_NOP2 = 4'b1111;

    // The ALU treats this code as a no-op, so it is parked here whenever nothing executes.
    localparam logic [OP_W-1:0] SEL_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WBHI = 2'd2
    } state_e;

    function automatic logic is_nop(input logic [OP_W-1:0] op);
        logic res;
        case (op)
            OP_NOP0, OP_NOP1, OP_NOP2: res = 1'b1;
            default:                   res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        logic res;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_NAND, OP_NOR, OP_XOR: res = 1'b1;
            OP_NOP0, OP_NOP1, OP_NOP2:                       res = 1'b1;
            default:                                         res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake bundle between an instruction source (master) and the sequencer (slave).
`timescale 1ns/1ps
interface alu_op_sequencer_if
    import alu_op_sequencer_pkg::*;
#(
    parameter int RW = 2
);
    logic            instr_valid;
    logic            instr_ready;
    logic [OP_W-1:0] instr_op;
    logic [RW-1:0]   instr_rd;
    logic [RW-1:0]   instr_rs1;
    logic [RW-1:0]   instr_rs2;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        output instr_ready
    );
endinterface

// File: rtl/alu_op_sequencer_regfile.sv
// Register file: NREG x DW bits, one synchronous write port, three asynchronous read ports.
`timescale 1ns/1ps
module alu_op_sequencer_regfile
    import alu_op_sequencer_pkg::*;
#(
    parameter int NREG = 4,
    parameter int DW   = DATA_W,
    localparam int RW  = $clog2(NREG)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [RW-1:0] wa_i,
    input  logic [DW-1:0] wd_i,
    input  logic [RW-1:0] ra1_i,
    output logic [DW-1:0] rd1_o,
    input  logic [RW-1:0] ra2_i,
    output logic [DW-1:0] rd2_o,
    input  logic [RW-1:0] ra3_i,
    output logic [DW-1:0] rd3_o
);

    logic [DW-1:0] mem_q [NREG];

    // Storage with asynchronous clear and a single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else if (we_i) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = mem_q[ra1_i];
    assign rd2_o = mem_q[ra2_i];
    assign rd3_o = mem_q[ra3_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Control side of the 4-bit ALU: accepts instructions, drives A/B/Sel, writes back F3 (and F4 for MUL).
// Build macro MUL_HI_WB_EN: MUL additionally writes its high nibble to reg[(rd+1) mod NREG].
`timescale 1ns/1ps
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int NREG = 4,
    parameter int DW   = DATA_W,
    localparam int RW  = $clog2(NREG)
)(
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave instr_if,
    output logic [DW-1:0]     alu_a_o,
    output logic [DW-1:0]     alu_b_o,
    output logic [OP_W-1:0]   alu_sel_o,
    input  logic [DW-1:0]     alu_f3_i,
    input  logic [DW-1:0]     alu_f4_i,
    input  logic              alu_c_i,
    input  logic              alu_v_i,
    output logic              flag_c_o,
    output logic              flag_v_o,
    output logic              flag_z_o,
    output logic              done_o,
    output logic              illegal_o,
    input  logic [RW-1:0]     dbg_addr_i,
    output logic [DW-1:0]     dbg_data_o
);

    state_e          state_q, state_d;
    logic [RW-1:0]   rd_q, rd_d;
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0] alu_sel_q, alu_sel_d;
    logic            flag_c_q, flag_c_d;
    logic            flag_v_q, flag_v_d;
    logic            flag_z_q, flag_z_d;
    logic            done_q, done_d;
    logic            illegal_q, illegal_d;
`ifdef MUL_HI_WB_EN
    logic [DW-1:0]   hi_q, hi_d;
`endif

    logic            we_s;
    logic [RW-1:0]   wa_s;
    logic [DW-1:0]   wd_s;
    logic [DW-1:0]   rs1_data_s;
    logic [DW-1:0]   rs2_data_s;

    alu_op_sequencer_regfile #(
        .NREG (NREG),
        .DW   (DW)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we_i  (we_s),
        .wa_i  (wa_s),
        .wd_i  (wd_s),
        .ra1_i (instr_if.instr_rs1),
        .rd1_o (rs1_data_s),
        .ra2_i (instr_if.instr_rs2),
        .rd2_o (rs2_data_s),
        .ra3_i (dbg_addr_i),
        .rd3_o (dbg_data_o)
    );

    assign instr_if.instr_ready = (state_q == ST_IDLE);

    // Next-state, operand latching, writeback and pulse generation.
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        flag_c_d  = flag_c_q;
        flag_v_d  = flag_v_q;
        flag_z_d  = flag_z_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        we_s      = 1'b0;
        wa_s      = rd_q;
        wd_s      = alu_f3_i;
`ifdef MUL_HI_WB_EN
        hi_d      = hi_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (instr_if.instr_valid) begin
                    // Operands are captured here so a later write to rd cannot disturb them.
                    if (is_legal(instr_if.instr_op)) begin
                        state_d   = ST_EXEC;
                        rd_d      = instr_if.instr_rd;
                        alu_a_d   = rs1_data_s;
                        alu_b_d   = rs2_data_s;
                        alu_sel_d = instr_if.instr_op;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                alu_a_d   = {DW{1'b0}};
                alu_b_d   = {DW{1'b0}};
                alu_sel_d = SEL_IDLE;
                if (!is_nop(alu_sel_q)) begin
                    we_s     = 1'b1;
                    flag_c_d = alu_c_i;
                    flag_v_d = alu_v_i;
                    if (alu_sel_q == OP_MUL) begin
                        flag_z_d = ({alu_f4_i, alu_f3_i} == {(2*DW){1'b0}});
                    end else begin
                        flag_z_d = (alu_f3_i == {DW{1'b0}});
                    end
                end else begin
                    we_s = 1'b0;
                end
`ifdef MUL_HI_WB_EN
                if (alu_sel_q == OP_MUL) begin
                    state_d = ST_WBHI;
                    hi_d    = alu_f4_i;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
`else
                state_d = ST_IDLE;
                done_d  = 1'b1;
`endif
            end
`ifdef MUL_HI_WB_EN
            ST_WBHI: begin
                we_s    = 1'b1;
                wa_s    = rd_q + RW'(1);
                wd_s    = hi_q;
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d   = ST_IDLE;
                alu_a_d   = {DW{1'b0}};
                alu_b_d   = {DW{1'b0}};
                alu_sel_d = SEL_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_q      <= {RW{1'b0}};
            alu_a_q   <= {DW{1'b0}};
            alu_b_q   <= {DW{1'b0}};
            alu_sel_q <= SEL_IDLE;
            flag_c_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef MUL_HI_WB_EN
            hi_q      <= {DW{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            flag_c_q  <= flag_c_d;
            flag_v_q  <= flag_v_d;
            flag_z_q  <= flag_z_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
`ifdef MUL_HI_WB_EN
            hi_q      <= hi_d;
`endif
        end
    end

    assign alu_a_o   = alu_a_q;
    assign alu_b_o   = alu_b_q;
    assign alu_sel_o = alu_sel_q;
    assign flag_c_o  = flag_c_q;
    assign flag_v_o  = flag_v_q;
    assign flag_z_o  = flag_z_q;
    assign done_o    = done_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU + architectural reference model, directed and random steps.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

    localparam int NREG = 4;
    localparam int RW   = 2;
`ifdef MUL_HI_WB_EN
    localparam bit HIWB = 1'b1;
`else
    localparam bit HIWB = 1'b0;
`endif

    localparam logic [3:0] ADD  = 4'b0001;
    localparam logic [3:0] SUB  = 4'b0011;
    localparam logic [3:0] MUL  = 4'b0111;
    localparam logic [3:0] NAND = 4'b1000;
    localparam logic [3:0] XOR  = 4'b1011;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    alu_a, alu_b, alu_sel, alu_f3, alu_f4;
    logic          alu_c, alu_v;
    logic          flag_c, flag_v, flag_z, done, illegal;
    logic [RW-1:0] dbg_addr;
    logic [3:0]    dbg_data;

    int checks = 0;
    int errors = 0;

    logic [3:0] mreg [NREG];
    logic       mc, mv, mz;

    alu_op_sequencer_if #(.RW(RW)) bus ();

    alu_op_sequencer #(.NREG(NREG)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_if   (bus),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_sel_o  (alu_sel),
        .alu_f3_i   (alu_f3),
        .alu_f4_i   (alu_f4),
        .alu_c_i    (alu_c),
        .alu_v_i    (alu_v),
        .flag_c_o   (flag_c),
        .flag_v_o   (flag_v),
        .flag_z_o   (flag_z),
        .done_o     (done),
        .illegal_o  (illegal),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    always #10 clk = ~clk;

    // Behavioural 4-bit ALU: returns {f4, f3, c, v}.
    function automatic logic [9:0] alu_fn(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
        int s, lo, p;
        logic [3:0] f3, f4;
        logic c, v;
        f3 = 4'd0; f4 = 4'd0; c = 1'b0; v = 1'b0;
        case (sel)
            ADD: begin
                s  = int'(a) + int'(b);
                lo = int'(a % 8) + int'(b % 8);
                f3 = 4'(s % 16); c = (s >= 16); v = (lo >= 8);
            end
            SUB: begin
                s  = int'(a) - int'(b);
                f3 = 4'((s + 16) % 16); c = (s >= 0);
                v  = (a[3] != b[3]) && (f3[3] != a[3]);
            end
            MUL: begin
                p  = int'(a) * int'(b);
                f3 = 4'(p % 16); f4 = 4'(p / 16); c = (p >= 16); v = (p >= 128);
            end
            NAND:    begin f3 = ~(a & b); c = a[0]; v = b[0]; end
            4'b1001: begin f3 = ~(a | b); c = a[1]; v = b[1]; end
            XOR:     begin f3 = a ^ b;    c = a[2]; v = b[2]; end
            default: begin f3 = 4'd0; end
        endcase
        return {f4, f3, c, v};
    endfunction

    assign {alu_f4, alu_f3, alu_c, alu_v} = alu_fn(alu_sel, alu_a, alu_b);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input int idx, output logic [3:0] val);
        dbg_addr = RW'(idx);
        #1;
        val = dbg_data;
    endtask

    // Compares all registers (through the debug port) and flags with the model.
    task automatic check_state(input string tag);
        logic [3:0] v;
        for (int i = 0; i < NREG; i++) begin
            read_reg(i, v);
            chk($sformatf("%s_r%0d", tag, i), 8'(v), 8'(mreg[i]));
        end
        chk({tag, "_fc"}, 8'(flag_c), 8'(mc));
        chk({tag, "_fv"}, 8'(flag_v), 8'(mv));
        chk({tag, "_fz"}, 8'(flag_z), 8'(mz));
    endtask

    task automatic model_retire(input logic [3:0] op, input logic [1:0] rd, input logic [3:0] a, input logic [3:0] b);
        logic [9:0] r;
        r = alu_fn(op, a, b);
        if (!(op inside {4'b1100, 4'b1110, 4'b1111})) begin
            mreg[rd] = r[5:2];
            mc = r[1];
            mv = r[0];
            mz = (op == MUL) ? (r[9:2] == 8'd0) : (r[5:2] == 4'd0);
        end
        if (HIWB && op == MUL) mreg[rd + 2'd1] = r[9:6];
    endtask

    task automatic exec_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        logic [3:0] ea, eb;
        bit legal;
        @(negedge clk);
        chk("ready_idle", 8'(bus.instr_ready), 8'd1);
        bus.instr_valid = 1'b1;
        bus.instr_op = op; bus.instr_rd = rd; bus.instr_rs1 = rs1; bus.instr_rs2 = rs2;
        ea = mreg[rs1]; eb = mreg[rs2];
        legal = op inside {4'b0001, 4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1011, 4'b1100, 4'b1110, 4'b1111};
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        if (!legal) begin
            chk("ill_pulse", 8'(illegal), 8'd1);
            chk("ill_nodone", 8'(done), 8'd0);
            chk("ill_sel", 8'(alu_sel), 8'hF);
            chk("ill_ready", 8'(bus.instr_ready), 8'd1);
            @(posedge clk); #1;
            chk("ill_clear", 8'(illegal), 8'd0);
            chk("ill_nodone2", 8'(done), 8'd0);
        end else begin
            chk("ex_sel", 8'(alu_sel), 8'(op));
            chk("ex_a", 8'(alu_a), 8'(ea));
            chk("ex_b", 8'(alu_b), 8'(eb));
            chk("ex_busy", 8'(bus.instr_ready), 8'd0);
            chk("ex_nodone", 8'(done), 8'd0);
            chk("ex_noill", 8'(illegal), 8'd0);
            model_retire(op, rd, ea, eb);
            if (HIWB && op == MUL) begin
                @(posedge clk); #1;
                chk("wbhi_nodone", 8'(done), 8'd0);
                chk("wbhi_busy", 8'(bus.instr_ready), 8'd0);
                chk("wbhi_sel", 8'(alu_sel), 8'hF);
            end
            @(posedge clk); #1;
            chk("ret_done", 8'(done), 8'd1);
            chk("ret_ready", 8'(bus.instr_ready), 8'd1);
            chk("ret_sel", 8'(alu_sel), 8'hF);
            chk("ret_a", 8'(alu_a), 8'd0);
        end
        check_state("st");
    endtask

    // Builds constant k in rd using helper register h (0 -> 15 -> 0-15 = 1, then repeated adds).
    task automatic load(input logic [1:0] rd, input logic [1:0] h, input int k);
        exec_instr(XOR, h, h, h);
        exec_instr(NAND, h, h, h);
        exec_instr(XOR, rd, rd, rd);
        exec_instr(SUB, h, rd, h);
        for (int i = 0; i < k; i++) exec_instr(ADD, rd, rd, h);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v;
        logic [3:0] ea, eb;
        logic [1:0] rd, rs1, rs2;

        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_op = 4'd0; bus.instr_rd = 2'd0; bus.instr_rs1 = 2'd0; bus.instr_rs2 = 2'd0;
        dbg_addr = 2'd0;
        for (int i = 0; i < NREG; i++) mreg[i] = 4'd0;
        mc = 1'b0; mv = 1'b0; mz = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_ill", 8'(illegal), 8'd0);
        chk("rst_a", 8'(alu_a), 8'd0);
        chk("rst_b", 8'(alu_b), 8'd0);
        chk("rst_sel", 8'(alu_sel), 8'hF);
        check_state("rst");
        @(negedge clk);
        rst = 1'b0;

        // ADD 7 + 9
        load(2'd0, 2'd3, 7);
        load(2'd1, 2'd3, 9);
        exec_instr(ADD, 2'd2, 2'd0, 2'd1);
        read_reg(2, v);
        chk("add_r2", 8'(v), 8'd0);
        chk("add_c", 8'(flag_c), 8'd1);
        chk("add_v", 8'(flag_v), 8'd1);
        chk("add_z", 8'(flag_z), 8'd1);

        // SUB 3 - 5
        load(2'd0, 2'd2, 3);
        load(2'd1, 2'd2, 5);
        exec_instr(SUB, 2'd3, 2'd0, 2'd1);
        read_reg(3, v);
        chk("sub_r3", 8'(v), 8'd14);

        // MUL 15 x 15 into r3, high nibble wraps to r0 when enabled
        load(2'd0, 2'd2, 15);
        load(2'd1, 2'd2, 15);
        exec_instr(MUL, 2'd3, 2'd0, 2'd1);
        read_reg(3, v);
        chk("mul_r3", 8'(v), 8'd1);
        read_reg(0, v);
        chk("mul_r0", 8'(v), HIWB ? 8'd14 : 8'd15);

        // MUL 4 x 4: low nibble zero, but the product is not
        load(2'd0, 2'd3, 4);
        load(2'd1, 2'd3, 4);
        exec_instr(MUL, 2'd2, 2'd0, 2'd1);
        read_reg(2, v);
        chk("mul44_r2", 8'(v), 8'd0);
        chk("mul44_z", 8'(flag_z), 8'd0);

        // Illegal opcode, then ADD followed by NOP
        exec_instr(4'b0101, 2'd1, 2'd0, 2'd0);
        load(2'd0, 2'd3, 4);
        exec_instr(ADD, 2'd2, 2'd0, 2'd1);
        exec_instr(4'b1110, 2'd2, 2'd0, 2'd0);
        read_reg(2, v);
        chk("nop_r2", 8'(v), 8'd8);
        chk("nop_v", 8'(flag_v), 8'd1);
        chk("nop_z", 8'(flag_z), 8'd0);

        // Back-to-back XORs with valid held high
        @(negedge clk);
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd = 2'($urandom_range(0, 3)); rs1 = 2'($urandom_range(0, 3)); rs2 = 2'($urandom_range(0, 3));
            bus.instr_op = XOR; bus.instr_rd = rd; bus.instr_rs1 = rs1; bus.instr_rs2 = rs2;
            ea = mreg[rs1]; eb = mreg[rs2];
            chk("b2b_ready", 8'(bus.instr_ready), 8'd1);
            @(posedge clk); #1;
            if (i == 3) bus.instr_valid = 1'b0;
            chk("b2b_busy", 8'(bus.instr_ready), 8'd0);
            chk("b2b_a", 8'(alu_a), 8'(ea));
            chk("b2b_b", 8'(alu_b), 8'(eb));
            model_retire(XOR, rd, ea, eb);
            bus.instr_rs1 = ~rs1;
            @(posedge clk); #1;
            chk("b2b_done", 8'(done), 8'd1);
            @(negedge clk);
        end
        check_state("b2b");

        // Random instructions, all sixteen opcodes
        for (int i = 0; i < 60; i++) begin
            exec_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        // Reset during EXEC of an ADD
        load(2'd0, 2'd3, 5);
        load(2'd1, 2'd3, 6);
        exec_instr(XOR, 2'd2, 2'd2, 2'd2);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op = ADD; bus.instr_rd = 2'd2; bus.instr_rs1 = 2'd0; bus.instr_rs2 = 2'd1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        chk("rx_sel", 8'(alu_sel), 8'(ADD));
        rst = 1'b1;
        #1;
        chk("rx_sel0", 8'(alu_sel), 8'hF);
        chk("rx_a0", 8'(alu_a), 8'd0);
        chk("rx_b0", 8'(alu_b), 8'd0);
        @(posedge clk); #1;
        chk("rx_nodone", 8'(done), 8'd0);
        for (int i = 0; i < NREG; i++) mreg[i] = 4'd0;
        mc = 1'b0; mv = 1'b0; mz = 1'b0;
        check_state("rx");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rx_after_done", 8'(done), 8'd0);
        read_reg(2, v);
        chk("rx_r2", 8'(v), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
